// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue wrapper: op encodings,
// parameter defaults and the op decoder.
package mul_pkg;

  localparam int MUL_LAT_DEF   = 1;
  localparam int BUF_DEPTH_DEF = 2;
  localparam int TAG_W_DEF     = 5;

  typedef enum logic [1:0] {
    MUL_OP_W    = 2'd0,
    MULH_W      = 2'd1,
    MULH_WU     = 2'd2,
    MUL_OP_RSVD = 2'd3
  } mul_op_e;

  typedef struct packed {
    logic is_signed;
    logic hi_sel;
  } mul_dec_t;

  // The reserved encoding decodes exactly like MUL.W.
  function automatic mul_dec_t mul_decode(input logic [1:0] op);
    mul_dec_t dec;
    dec.is_signed = 1'b1;
    dec.hi_sel    = 1'b0;
    case (mul_op_e'(op))
      MULH_W:  dec.hi_sel = 1'b1;
      MULH_WU: begin
        dec.hi_sel    = 1'b1;
        dec.is_signed = 1'b0;
      end
      default: ;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Result buffer between the fixed-latency multiplier and MEM: circular FIFO
// with simultaneous push/pop, flush and an occupancy count.
module mul_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is cleared on reset only so the head word reads as zero
      // straight out of reset; a flush just rewinds the pointers.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (!push_i && pop_i) count_q <= count_q - 1'b1;
    end
  end

  // Issue credits guarantee a free slot for every op leaving the core.
  always_ff @(posedge clk_i) begin
    if (resetn_i && !flush_i) begin
      assert (!(push_i && !pop_i && count_q == CNT_W'(DEPTH)))
        else $error("mul_result_fifo: push into full buffer");
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/retire control around the non-stallable Booth/Wallace multiplier:
// op decode, in-flight tracking, result word select and credit-based issue.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LAT   = MUL_LAT_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic             mul_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  output logic             core_signed,
  input  logic [63:0]      core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = $clog2(BUF_DEPTH + MUL_LAT + 1) + 1;

  typedef struct packed {
    logic             valid;
    logic             hi_sel;
    logic [TAG_W-1:0] tag;
  } track_t;

  track_t           track_q [MUL_LAT];
  track_t           track_d [MUL_LAT];
  track_t           track_last;
  logic             resetn_q;
  mul_dec_t         dec;
  logic             fire;
  logic             push;
  logic             pop;
  logic [31:0]      sel_word;
  logic [TAG_W+31:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occ;

  assign dec         = mul_decode(in_op);
  assign core_a      = in_src1;
  assign core_b      = in_src2;
  assign core_signed = dec.is_signed;
  assign fire        = in_valid & in_ready;

  // Ops leave the core in issue order, so the last track stage describes
  // whatever core_result carries this cycle.
  assign track_last = track_q[MUL_LAT-1];
  assign push       = track_last.valid;
  assign sel_word   = track_last.hi_sel ? core_result[63:32] : core_result[31:0];

  // Ops accepted but not yet popped: buffered plus in the core, less any
  // result leaving this cycle. One more may issue only if it still fits.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch can be inferred.
    occ = OCC_W'(fifo_count);
    for (int i = 0; i < MUL_LAT; i++) occ = occ + OCC_W'(track_q[i].valid);
    if (pop) occ = occ - OCC_W'(1);
  end

  assign in_ready = resetn_q & ~flush & (occ < OCC_W'(BUF_DEPTH));

  always_comb begin
    track_d[0].valid  = fire;
    track_d[0].hi_sel = dec.hi_sel;
    track_d[0].tag    = in_tag;
    for (int i = 1; i < MUL_LAT; i++) track_d[i] = track_q[i-1];
  end

  always_ff @(posedge mul_clk) begin
    // NOTE: clocked state always uses non-blocking '<=' so every register
    // samples its pre-edge inputs regardless of statement order.
    resetn_q <= resetn;
    if (!resetn || flush) begin
      for (int i = 0; i < MUL_LAT; i++) track_q[i] <= '0;
    end else begin
      track_q <= track_d;
    end
  end

  mul_result_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (TAG_W + 32)
  ) u_result_fifo (
    .clk_i       (mul_clk),
    .resetn_i    (resetn),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({track_last.tag, sel_word}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_head[31:0];
  assign out_tag   = fifo_head[TAG_W+31:32];

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed and random ops against a
// queue-based reference model with a behavioural one-cycle multiplier core.
module tb_mul_issue_ctrl;

  localparam int MUL_LAT   = 1;
  localparam int BUF_DEPTH = 2;
  localparam int TAG_W     = 5;

  logic             mul_clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic [31:0]      core_a;
  logic [31:0]      core_b;
  logic             core_signed;
  logic [63:0]      core_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  always #5 mul_clk = ~mul_clk;

  mul_issue_ctrl #(
    .MUL_LAT   (MUL_LAT),
    .BUF_DEPTH (BUF_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .mul_clk     (mul_clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .in_tag      (in_tag),
    .flush       (flush),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_signed (core_signed),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  // One-cycle multiplier core.
  always @(posedge mul_clk) begin
    if (core_signed) core_result <= 64'(longint'($signed(core_a)) * longint'($signed(core_b)));
    else             core_result <= {32'b0, core_a} * {32'b0, core_b};
  end

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          rst_ok   = 1'b0;
  bit          last_fire = 1'b0;
  bit          use_const = 1'b0;
  logic [31:0] const_val = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (op)
      2'd1:    return sp[63:32];
      2'd2:    return up[63:32];
      default: return sp[31:0];
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: inputs were set at the preceding negedge; compare
  // outputs mid-cycle, update the model, then advance to the next negedge.
  task automatic step();
    exp_t e;
    bit   exp_ov;
    bit   exp_rdy;
    bit   pop;
    int   qs;
    #1;
    qs      = exp_q.size();
    exp_ov  = (qs > 0) && (exp_q[0].rdy <= cyc);
    pop     = exp_ov && out_ready;
    exp_rdy = rst_ok && !flush && ((qs - (pop ? 1 : 0)) < BUF_DEPTH);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_ov);
    if (!rst_ok) begin
      check("reset_out_data", out_data, 0);
      check("reset_out_tag", out_tag, 0);
    end
    if (pop) begin
      check("out_data", out_data, exp_q[0].data);
      check("out_tag", out_tag, exp_q[0].tag);
      void'(exp_q.pop_front());
    end
    last_fire = in_valid && in_ready;
    if (last_fire) begin
      e.data = use_const ? const_val : ref_mul(in_op, in_src1, in_src2);
      e.tag  = in_tag;
      e.rdy  = cyc + MUL_LAT + 1;
      exp_q.push_back(e);
    end
    if (!resetn || flush) exp_q.delete();
    rst_ok = resetn;
    @(posedge mul_clk);
    cyc++;
    @(negedge mul_clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [31:0] want);
    int n = 0;
    in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    use_const = 1'b1;
    const_val = want;
    do begin
      step();
      n++;
    end while (!last_fire && n < 10);
    check("issue_accept", last_fire, 1);
    in_valid  = 1'b0;
    use_const = 1'b0;
    drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int n;
    int offered;
    int accepted;

    resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge mul_clk);
    @(negedge mul_clk);
    resetn = 1'b1;
    step();
    step();

    // Directed results.
    run_one(2'd0, 32'd3,         32'hFFFF_FFFB, 5'd7, 32'hFFFF_FFF1);
    run_one(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000);
    run_one(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE);
    run_one(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000);
    run_one(2'd3, 32'h0001_0000, 32'h0001_0003, 5'd11, 32'h0003_0000);

    // Back-to-back with MEM stalled: only BUF_DEPTH ops may be accepted.
    idx = 1;
    in_op = 2'd0; in_src1 = $urandom; in_src2 = $urandom; in_tag = 5'd1;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (6) begin
      step();
      if (last_fire) begin
        idx++;
        if (idx <= 4) begin in_src1 = $urandom; in_src2 = $urandom; in_tag = 5'(idx); end
        else in_valid = 1'b0;
      end
    end
    check("b2b_accepted_blocked", idx - 1, 2);
    out_ready = 1'b1;
    n = 0;
    while (idx <= 4 && n < 30) begin
      step();
      n++;
      if (last_fire) begin
        idx++;
        if (idx <= 4) begin in_src1 = $urandom; in_src2 = $urandom; in_tag = 5'(idx); end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_all_accepted", idx - 1, 4);
    drain(30);

    // Random stream with random back-pressure.
    offered = 0; accepted = 0;
    for (int c = 0; c < 1000 && (accepted < 20 || exp_q.size() > 0); c++) begin
      if (!in_valid || last_fire) begin
        in_valid = 1'b0;
        if (offered < 20 && $urandom_range(0, 3) != 0) begin
          in_op = 2'($urandom_range(0, 3)); in_src1 = rand_word(); in_src2 = rand_word();
          in_tag = 5'($urandom); in_valid = 1'b1; offered++;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_fire) accepted++;
    end
    in_valid = 1'b0;
    check("rand_accepted", accepted, 20);
    check("rand_drained", exp_q.size(), 0);

    // Flush the cycle after issue: killed op must never surface.
    out_ready = 1'b1;
    in_op = 2'd0; in_src1 = 32'd5; in_src2 = 32'd6; in_tag = 5'd20; in_valid = 1'b1;
    step();
    check("flush_victim_accept", last_fire, 1);
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    run_one(2'd2, 32'h0000_0002, 32'h8000_0000, 5'd21, 32'h0000_0001);
    repeat (3) step();

    // Reset with two results buffered.
    out_ready = 1'b0;
    in_op = 2'd0; in_src1 = 32'd7; in_src2 = 32'd9; in_tag = 5'd3; in_valid = 1'b1;
    n = 0;
    idx = 0;
    while (idx < 2 && n < 10) begin
      step();
      n++;
      if (last_fire) idx++;
    end
    in_valid = 1'b0;
    check("rst_prefill", idx, 2);
    repeat (3) step();
    check("rst_buffered", exp_q.size(), 2);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    step();
    run_one(2'd0, 32'h1234_5678, 32'd16, 5'd31, 32'h2345_6780);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
